calc_hist: RTL and testbench

- Parametrised successor of the board accumulator calculator.
- Holds a WIDTH-bit signed accumulator that is updated from the switches by a button-selected operation.
- Adds per-button synchronisation and debounce, so each press executes exactly once.
- Adds signed-overflow reporting and a circular undo history of HIST_DEPTH previous accumulator values.
- Sits directly between the board I/O (switches, buttons, LEDs) and the user.

---
 rtl/calc_hist.sv | 154 +++++++++++++++
 tb/tb_calc_hist.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_hist.sv
// Accumulator calculator with debounced execute/undo buttons, signed overflow
// flag and a circular undo history of previous accumulator values.

module calc_hist_debounce #(
    parameter int DEBOUNCE = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          deb_d;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level, so any bounce back restarts the stability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pulse = deb & ~deb_d;
endmodule

module calc_hist #(
    parameter int WIDTH      = 16,
    parameter int HIST_DEPTH = 8,
    parameter int DEBOUNCE   = 100000
) (
    input  logic             clk,
    input  logic             btnu,
    input  logic [WIDTH-1:0] sw,
    input  logic             btnl,
    input  logic             btnc,
    input  logic             btnr,
    input  logic             btnd,
    input  logic             btn_undo,
    output logic [WIDTH-1:0] led,
    output logic             ovf,
    output logic             hist_empty
);
    localparam int SW = $clog2(WIDTH);
    localparam int HW = $clog2(HIST_DEPTH);
    localparam logic [HW:0] FULL = (HW + 1)'(HIST_DEPTH);

    logic             exec_pulse;
    logic             undo_pulse;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result;
    logic             res_ovf;
    logic [2:0]       op;
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] hist_mem [HIST_DEPTH];
    logic [HW-1:0]    wr_ptr;
    logic [HW:0]      count;
    logic             do_push;

    calc_hist_debounce #(.DEBOUNCE(DEBOUNCE)) u_exec_db (
        .clk   (clk),
        .rst   (btnu),
        .raw   (btnd),
        .pulse (exec_pulse)
    );

    calc_hist_debounce #(.DEBOUNCE(DEBOUNCE)) u_undo_db (
        .clk   (clk),
        .rst   (btnu),
        .raw   (btn_undo),
        .pulse (undo_pulse)
    );

    assign op = {btnl, btnc, btnr};
    assign sh = sw[SW-1:0];

    always_comb begin
        result  = acc;
        res_ovf = 1'b0;
        case (op)
            3'b000: result = acc & sw;
            3'b001: result = acc | sw;
            3'b010: begin
                result  = acc + sw;
                res_ovf = (acc[WIDTH-1] == sw[WIDTH-1]) && (result[WIDTH-1] != acc[WIDTH-1]);
            end
            3'b011: begin
                result  = acc - sw;
                res_ovf = (acc[WIDTH-1] != sw[WIDTH-1]) && (result[WIDTH-1] != acc[WIDTH-1]);
            end
            3'b100: result = acc ^ sw;
            3'b101: result = acc << sh;
            3'b110: result = $signed(acc) >>> sh;
            default: result = sw;
        endcase
    end

    // Undo takes priority, so an execute pulse landing in the same cycle is dropped.
    assign do_push = exec_pulse && !undo_pulse;

    always_ff @(posedge clk) begin
        if (btnu) begin
            acc    <= '0;
            ovf    <= 1'b0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (undo_pulse) begin
            if (count != '0) begin
                acc    <= hist_mem[wr_ptr - 1'b1];
                wr_ptr <= wr_ptr - 1'b1;
                count  <= count - 1'b1;
                ovf    <= 1'b0;
            end
        end else if (exec_pulse) begin
            acc    <= result;
            ovf    <= res_ovf;
            wr_ptr <= wr_ptr + 1'b1;
            if (count != FULL) begin
                count <= count + 1'b1;
            end
        end
    end

    // A full buffer simply wraps, which overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (!btnu && do_push) begin
            hist_mem[wr_ptr] <= acc;
        end
    end

    assign led        = acc;
    assign hist_empty = (count == '0);
endmodule

// File: tb/tb_calc_hist.sv
// Scoreboard bench for calc_hist: stimulus queues timed expectations from a
// queue-based reference model, a negedge monitor pops and compares them.

module tb_calc_hist;
    localparam int W  = 16;
    localparam int HD = 4;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         btnu = 1'b1;
    logic [W-1:0] sw = '0;
    logic         btnl = 1'b0;
    logic         btnc = 1'b0;
    logic         btnr = 1'b0;
    logic         btnd = 1'b0;
    logic         btn_undo = 1'b0;
    logic [W-1:0] led;
    logic         ovf;
    logic         hist_empty;

    calc_hist #(.WIDTH(W), .HIST_DEPTH(HD), .DEBOUNCE(DB)) dut (
        .clk        (clk),
        .btnu       (btnu),
        .sw         (sw),
        .btnl       (btnl),
        .btnc       (btnc),
        .btnr       (btnr),
        .btnd       (btnd),
        .btn_undo   (btn_undo),
        .led        (led),
        .ovf        (ovf),
        .hist_empty (hist_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [W-1:0] led;
        logic         ovf;
        logic         empty;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: accumulator, overflow flag and a bounded history queue
    logic [W-1:0] m_acc = '0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] m_hist[$];

    function automatic void model_reset();
        m_acc = '0;
        m_ovf = 1'b0;
        m_hist.delete();
    endfunction

    function automatic void model_exec(input logic [2:0] op, input logic [W-1:0] b);
        int sa, sb2, r, sh;
        sa  = $signed(m_acc);
        sb2 = $signed(b);
        sh  = int'(b[3:0]);
        m_hist.push_back(m_acc);
        if (m_hist.size() > HD) void'(m_hist.pop_front());
        m_ovf = 1'b0;
        case (op)
            3'd0: r = sa & sb2;
            3'd1: r = sa | sb2;
            3'd2: begin r = sa + sb2; m_ovf = (r > 2**(W-1) - 1) || (r < -(2**(W-1))); end
            3'd3: begin r = sa - sb2; m_ovf = (r > 2**(W-1) - 1) || (r < -(2**(W-1))); end
            3'd4: r = sa ^ sb2;
            3'd5: r = sa << sh;
            3'd6: r = sa >>> sh;
            default: r = sb2;
        endcase
        m_acc = r[W-1:0];
    endfunction

    function automatic void model_undo();
        if (m_hist.size() > 0) begin
            m_acc = m_hist.pop_back();
            m_ovf = 1'b0;
        end
    endfunction

    function automatic void expect_at(input int due, input string name);
        exp_t e;
        e.due   = due;
        e.led   = m_acc;
        e.ovf   = m_ovf;
        e.empty = (m_hist.size() == 0);
        e.name  = name;
        sb.push_back(e);
    endfunction

    function automatic void checkOutput(input exp_t e);
        checks++;
        if (led !== e.led || ovf !== e.ovf || hist_empty !== e.empty) begin
            errors++;
            $display("[TB] FAIL %s @cycle %0d: got led=%h ovf=%b empty=%b, required led=%h ovf=%b empty=%b",
                     e.name, cyc, led, ovf, hist_empty, e.led, e.ovf, e.empty);
        end
    endfunction

    // Monitor: compares every expectation exactly on its due cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: check missed, due cycle %0d, now cycle %0d", e.name, e.due, cyc);
            end else begin
                checkOutput(e);
            end
        end
    end

    task automatic doReset();
        int n;
        @(posedge clk); #1;
        btnu = 1'b1;
        n = cyc;
        model_reset();
        expect_at(n + 1, "reset");
        @(posedge clk); #1;
        btnu = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic applyStimulus(input bit ex, input bit un, input logic [2:0] op,
                                 input logic [W-1:0] val, input int hold, input string name);
        int n;
        @(posedge clk); #1;
        {btnl, btnc, btnr} = op;
        sw       = val;
        btnd     = ex;
        btn_undo = un;
        n = cyc;
        expect_at(n + 3 + DB, {name, "_pre"});
        if (un) model_undo();
        else if (ex) model_exec(op, val);
        expect_at(n + 4 + DB, name);
        for (int i = 1; n + 4 + DB + 10 * i < n + hold; i++) expect_at(n + 4 + DB + 10 * i, {name, "_hold"});
        repeat (hold) @(posedge clk);
        #1;
        btnd     = 1'b0;
        btn_undo = 1'b0;
        repeat (DB + 6) @(posedge clk);
    endtask

    task automatic glitch();
        int n;
        @(posedge clk); #1;
        {btnl, btnc, btnr} = 3'b010;
        sw   = 16'h0001;
        btnd = 1'b1;
        n = cyc;
        repeat (3) @(posedge clk);
        #1;
        btnd = 1'b0;
        expect_at(n + DB + 10, "glitch");
        repeat (DB + 12) @(posedge clk);
    endtask

    task automatic resetDuringPulse();
        int n;
        @(posedge clk); #1;
        {btnl, btnc, btnr} = 3'b111;
        sw   = 16'h5A5A;
        btnd = 1'b1;
        n = cyc;
        expect_at(n + 3 + DB, "rstpulse_pre");
        repeat (3 + DB) @(posedge clk);
        #1;
        btnu = 1'b1;
        btnd = 1'b0;
        model_reset();
        expect_at(n + 4 + DB, "rstpulse");
        @(posedge clk); #1;
        btnu = 1'b0;
        expect_at(n + 4 + DB + 2 * DB + 8, "rstpulse_after");
        repeat (3 * DB + 10) @(posedge clk);
    endtask

    initial begin
        int sel;
        doReset();

        applyStimulus(1, 0, 3'b111, 16'h1234, 50, "load1234");
        glitch();

        applyStimulus(1, 0, 3'b111, 16'h7FFF, DB + 4, "load7fff");
        applyStimulus(1, 0, 3'b010, 16'h0001, DB + 4, "add_ovf");
        applyStimulus(1, 0, 3'b000, 16'hFFFF, DB + 4, "and_clr");

        applyStimulus(1, 0, 3'b111, 16'h8001, DB + 4, "load8001");
        applyStimulus(1, 0, 3'b110, 16'h0004, DB + 4, "sra4");
        applyStimulus(1, 0, 3'b111, 16'h0001, DB + 4, "load1");
        applyStimulus(1, 0, 3'b101, 16'h0013, DB + 4, "sll3");

        for (int v = 1; v <= 6; v++) applyStimulus(1, 0, 3'b111, W'(v), DB + 4, "hist_load");
        for (int u = 0; u < 6; u++) applyStimulus(0, 1, 3'b000, 16'h0000, DB + 4, "undo");

        applyStimulus(1, 0, 3'b111, 16'h1111, DB + 4, "load1111");
        applyStimulus(1, 0, 3'b111, 16'h2222, DB + 4, "load2222");
        applyStimulus(1, 1, 3'b010, 16'h0005, DB + 4, "exec_undo");

        resetDuringPulse();

        for (int r = 0; r < 40; r++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)
                applyStimulus(1, 0, 3'($urandom_range(0, 7)), W'($urandom_range(0, 65535)), DB + 4, "rnd_exec");
            else if (sel < 9)
                applyStimulus(0, 1, 3'b000, W'($urandom_range(0, 65535)), DB + 4, "rnd_undo");
            else
                applyStimulus(1, 1, 3'($urandom_range(0, 7)), W'($urandom_range(0, 65535)), DB + 4, "rnd_both");
        end

        for (int t = 0; t < 100 && sb.size() > 0; t++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end
endmodule
